// File: rtl/alu_mode_unit.sv
// -----------------------------------------------------------------------------
// alu_mode_unit
//
// Purpose:
//   Button-controlled ALU. Two raw push-buttons step a saturating mode
//   register. The mode register picks one of up to eight operations. Each
//   operation runs on two WIDTH-bit operands, and the result and flags are
//   registered with one cycle of latency. Both buttons are synchronised and
//   debounced inside this block.
//
// Parameters:
//   WIDTH            operand/result width in bits (2..32)
//   NUM_MODES        number of selectable ops (1..8), mode range 0..NUM_MODES-1
//   DEBOUNCE_CYCLES  consecutive synced samples that differ from the debounced
//                    level before the new level is accepted (>=1)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active-low
//   control_up    in   raw async button, active-high, mode +1
//   control_down  in   raw async button, active-high, mode -1
//   in_valid      in   a/b are sampled this cycle
//   a, b          in   WIDTH-bit two's complement operands
//   control_led   out  current mode register
//   out_valid     out  result/flags were updated on the last edge
//   result        out  registered ALU result
//   carry         out  carry-out (add/sub only; for sub, 1 = no borrow)
//   zero          out  result == 0
//   overflow      out  signed overflow (add/sub only)
// -----------------------------------------------------------------------------
module alu_mode_unit #(
  parameter int WIDTH           = 4,
  parameter int NUM_MODES       = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             control_up,
  input  logic             control_down,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       control_led,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  // The counter only needs to reach DEBOUNCE_CYCLES, because it clears as
  // soon as it gets there.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [2:0] MODE_MAX = 3'(NUM_MODES - 1);
  localparam int MSB = WIDTH - 1;

  // Operation codes for the mode register.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  // Bit 0 carries the up button and bit 1 carries the down button, all the
  // way through the button path.
  logic [1:0] btn_raw;
  logic [1:0] sync1_d, sync1_q;
  logic [1:0] sync2_d, sync2_q;
  logic [1:0] lvl_d, lvl_q;
  logic [1:0] lvl_dly_d, lvl_dly_q;
  logic [CNT_W-1:0] cnt_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0] press;

  logic [2:0] mode_d, mode_q;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;

  assign btn_raw = {control_down, control_up};

  // Button path. A 2-FF synchroniser feeds a debouncer. The debouncer counts
  // how many cycles in a row the synced level has differed from the accepted
  // level. Any sample that agrees with the accepted level restarts the count,
  // so short glitches never get through.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    lvl_d     = lvl_q;
    lvl_dly_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] + CNT_W'(1) == CNT_TARGET) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press pulse fires only on the rising edge of the debounced level. A
  // held button therefore steps the mode once, and a release does nothing.
  assign press = lvl_q & ~lvl_dly_q;

  // Saturating mode register. Simultaneous pulses cancel out.
  always_comb begin
    mode_d = mode_q;
    if (press[0] && !press[1] && (mode_q < MODE_MAX)) begin
      mode_d = mode_q + 3'd1;
    end else if (press[1] && !press[0] && (mode_q != 3'd0)) begin
      mode_d = mode_q - 3'd1;
    end
  end

  // ALU datapath. The add and subtract sums are formed one bit wider than
  // the operands so that the top bit is the carry-out. Subtraction uses
  // a + ~b + 1, so a carry of 1 means no borrow occurred.
  always_comb begin
    add_ext   = {1'b0, a} + {1'b0, b};
    sub_ext   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (mode_q)
      OP_ADD: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
        alu_ovf   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
        alu_ovf   = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
      end
      OP_NOT: alu_res = ~a;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      // A true signed compare. It gives the right answer even where a - b
      // would overflow.
      OP_SLT: alu_res[0] = ($signed(a) < $signed(b));
      OP_EQ:  alu_res[0] = (a == b);
      default: alu_res = '0;
    endcase
  end

  // Output register. It loads only when an operand pair arrives, and
  // otherwise it holds its value while out_valid drops.
  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    if (in_valid) begin
      result_d   = alu_res;
      carry_d    = alu_carry;
      zero_d     = (alu_res == '0);
      overflow_d = alu_ovf;
    end
  end

  // State registers. Reset overrides everything, including any debounce in
  // progress and any op sampled on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lvl_q       <= '0;
      lvl_dly_q   <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      lvl_q       <= lvl_d;
      lvl_dly_q   <= lvl_dly_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign control_led = mode_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign overflow    = overflow_q;

endmodule
